weight_seq_ctrl: RTL and testbench

Controller that sequences the clause-weight store in the classifier datapath. It accepts a stream of 256-bit weight beats and writes them into the store at offsets 0..BEATS-1. On command, it walks clause_no over all active clauses and accumulates the signed 9-bit weights of firing clauses into one class sum. It sits between the weight DMA/stream source and the weight store, and hands class_sum to the argmax stage.

---
 rtl/weight_seq_ctrl_pkg.sv | 16 +
 rtl/weight_seq_ctrl_if.sv | 40 ++++
 rtl/weight_seq_ctrl_loader.sv | 57 +++++
 rtl/weight_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_weight_seq_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/weight_seq_ctrl_pkg.sv
// Shared types and constants for the clause-weight store controller.
package weight_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, EVAL, DRAIN, DONE} state_e;

  localparam int BEATS     = 5;
  localparam int W_BITS    = 9;
  localparam int BEAT_BITS = 256;
  localparam int BCNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Widest sum supported is 32 bits; callers truncate to their SUM_W.
  function automatic logic signed [31:0] sext_weight(input logic [W_BITS-1:0] w);
    return {{(32-W_BITS){w[W_BITS-1]}}, w};
  endfunction

endpackage

// File: rtl/weight_seq_ctrl_if.sv
// Stream, store and command signals between the controller and its neighbours.
interface weight_seq_ctrl_if
  import weight_ctrl_pkg::*;
#(
  parameter int CLAUSEN = 10,
  parameter int SUM_W   = 16
);
  localparam int CW = $clog2(CLAUSEN) + 1;

  logic                       load_start;
  logic                       s_valid;
  logic [BEAT_BITS-1:0]       s_data;
  logic                       s_ready;
  logic                       start;
  logic [CW-1:0]              clauses;
  logic [CLAUSEN-1:0]         clause_fire;
  logic                       wa_valid;
  logic [BEAT_BITS-1:0]       wa_weight_write;
  logic [31:0]                wa_offset;
  logic [CW-1:0]              wa_clause_no;
  logic [W_BITS-1:0]          wa_weight;
  logic signed [SUM_W-1:0]    class_sum;
  logic                       done;
  logic                       busy;
  logic                       loaded;
  logic                       err;

  modport slave (
    input  load_start, s_valid, s_data, start, clauses, clause_fire, wa_weight,
    output s_ready, wa_valid, wa_weight_write, wa_offset, wa_clause_no,
           class_sum, done, busy, loaded, err
  );

  modport master (
    output load_start, s_valid, s_data, start, clauses, clause_fire, wa_weight,
    input  s_ready, wa_valid, wa_weight_write, wa_offset, wa_clause_no,
           class_sum, done, busy, loaded, err
  );

endinterface

// File: rtl/weight_seq_ctrl_loader.sv
// Beat loader: accepts weight beats while enabled and registers the store write port.
module weight_beat_loader
  import weight_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_go_i,
  input  logic                 s_valid_i,
  input  logic [BEAT_BITS-1:0] s_data_i,
  output logic                 s_ready_o,
  output logic                 load_last_o,
  output logic                 wa_valid_o,
  output logic [BEAT_BITS-1:0] wa_weight_write_o,
  output logic [31:0]          wa_offset_o
);
  logic [BCNT_W-1:0]    cnt_q, cnt_d;
  logic                 wa_valid_q, wa_valid_d;
  logic [BEAT_BITS-1:0] data_q, data_d;
  logic [31:0]          offset_q, offset_d;
  logic                 hs;

  assign s_ready_o   = load_go_i;
  assign hs          = load_go_i && s_valid_i;
  assign load_last_o = hs && (cnt_q == BCNT_W'(BEATS - 1));

  // Counter is held at zero outside a load so every image starts at offset 0.
  always_comb begin
    cnt_d      = load_go_i ? cnt_q : '0;
    data_d     = data_q;
    offset_d   = offset_q;
    wa_valid_d = hs;
    if (hs) begin
      data_d   = s_data_i;
      offset_d = 32'(cnt_q);
      cnt_d    = load_last_o ? '0 : cnt_q + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wa_valid_q <= 1'b0;
      data_q     <= '0;
      offset_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      wa_valid_q <= wa_valid_d;
      data_q     <= data_d;
      offset_q   <= offset_d;
    end
  end

  assign wa_valid_o        = wa_valid_q;
  assign wa_weight_write_o = data_q;
  assign wa_offset_o       = offset_q;

endmodule

// File: rtl/weight_seq_ctrl.sv
// Sequencer for the clause-weight store: image load, then per-pass weighted sum of firing clauses.
module weight_seq_ctrl
  import weight_ctrl_pkg::*;
#(
  parameter int CLAUSEN = 10,
  parameter int SUM_W   = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  weight_seq_ctrl_if.slave  bus
);
  localparam int CW = $clog2(CLAUSEN) + 1;

  state_e                  state_q, state_d;
  logic [CW-1:0]           k_q, k_d;
  logic [CW-1:0]           clauses_q, clauses_d;
  logic [CLAUSEN-1:0]      fire_q, fire_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] class_sum_q, class_sum_d;
  logic                    loaded_q, loaded_d;
  logic                    err_q, err_d;
  logic                    load_last;
  logic                    start_ok;
  logic signed [SUM_W-1:0] w_ext;
  logic [CLAUSEN-1:0]      fire_prev, fire_cur;

  weight_beat_loader u_loader (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_go_i         (state_q == LOAD),
    .s_valid_i         (bus.s_valid),
    .s_data_i          (bus.s_data),
    .s_ready_o         (bus.s_ready),
    .load_last_o       (load_last),
    .wa_valid_o        (bus.wa_valid),
    .wa_weight_write_o (bus.wa_weight_write),
    .wa_offset_o       (bus.wa_offset)
  );

  assign w_ext     = SUM_W'(sext_weight(bus.wa_weight));
  assign fire_prev = fire_q >> (k_q - CW'(1));
  assign fire_cur  = fire_q >> k_q;
  assign start_ok  = loaded_q && (bus.clauses >= CW'(1)) && (bus.clauses <= CW'(CLAUSEN));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    clauses_d   = clauses_q;
    fire_d      = fire_q;
    acc_d       = acc_q;
    class_sum_d = class_sum_q;
    loaded_d    = loaded_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          loaded_d = 1'b0;
          err_d    = 1'b0;
          state_d  = LOAD;
        end else if (bus.start) begin
          if (start_ok) begin
            clauses_d = bus.clauses;
            fire_d    = bus.clause_fire;
            acc_d     = '0;
            k_d       = '0;
            state_d   = EVAL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_last) begin
          loaded_d = 1'b1;
          state_d  = IDLE;
        end
      end
      EVAL: begin
        // Store data lags the index by one cycle, so accumulate clause k-1.
        if ((k_q != '0) && fire_prev[0]) acc_d = acc_q + w_ext;
        if (k_q == clauses_q - CW'(1)) state_d = DRAIN;
        else                           k_d     = k_q + CW'(1);
      end
      DRAIN: begin
        if (fire_cur[0]) acc_d = acc_q + w_ext;
        // Publish here so class_sum is already valid while done is high.
        class_sum_d = acc_d;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      clauses_q   <= '0;
      fire_q      <= '0;
      acc_q       <= '0;
      class_sum_q <= '0;
      loaded_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      clauses_q   <= clauses_d;
      fire_q      <= fire_d;
      acc_q       <= acc_d;
      class_sum_q <= class_sum_d;
      loaded_q    <= loaded_d;
      err_q       <= err_d;
    end
  end

  assign bus.wa_clause_no = k_q;
  assign bus.class_sum    = class_sum_q;
  assign bus.done         = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.loaded       = loaded_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Directed bench for weight_seq_ctrl: loads, evaluation sums, command errors, async reset.
module tb_weight_seq_ctrl;
  import weight_ctrl_pkg::*;

  localparam int CLAUSEN = 10;
  localparam int SUM_W   = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [W_BITS-1:0] wtab [0:31];

  weight_seq_ctrl_if #(.CLAUSEN(CLAUSEN), .SUM_W(SUM_W)) bus ();

  weight_seq_ctrl #(.CLAUSEN(CLAUSEN), .SUM_W(SUM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store model: one-cycle read latency.
  always @(posedge clk) bus.wa_weight <= wtab[bus.wa_clause_no];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BEAT_BITS-1:0] pat(input int b);
    return {64'hC0DE_0000_0000_0000 + 64'(b), 128'h0, 64'h5A00 + 64'(b)};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".s_ready"},   longint'(bus.s_ready), 0);
    check({tag, ".wa_valid"},  longint'(bus.wa_valid), 0);
    check({tag, ".done"},      longint'(bus.done), 0);
    check({tag, ".busy"},      longint'(bus.busy), 0);
    check({tag, ".loaded"},    longint'(bus.loaded), 0);
    check({tag, ".err"},       longint'(bus.err), 0);
    check({tag, ".class_sum"}, longint'(bus.class_sum), 0);
    check({tag, ".offset"},    longint'(bus.wa_offset), 0);
    check({tag, ".clause_no"}, longint'(bus.wa_clause_no), 0);
    check({tag, ".wdata"},     longint'(bus.wa_weight_write[63:0]), 0);
  endtask

  // gap_after[i]=1 inserts one idle cycle after beat i.
  task automatic load_image(input logic [7:0] gap_after);
    logic [BEAT_BITS-1:0] d;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check("load.busy", longint'(bus.busy), 1);
    check("load.err_cleared", longint'(bus.err), 0);
    for (int b = 0; b < BEATS; b++) begin
      d = pat(b);
      check("load.s_ready", longint'(bus.s_ready), 1);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      tick();
      bus.s_valid = 1'b0;
      check("load.wa_valid", longint'(bus.wa_valid), 1);
      check("load.offset", longint'(bus.wa_offset), longint'(b));
      check("load.wdata_lo", longint'(bus.wa_weight_write[63:0]), longint'(64'h5A00 + 64'(b)));
      check("load.wdata_hi", longint'(bus.wa_weight_write[255:192]),
            longint'(64'hC0DE_0000_0000_0000 + 64'(b)));
      if (b < BEATS - 1) check("load.loaded_early", longint'(bus.loaded), 0);
      $display("load beat %0d -> offset %0d", b, bus.wa_offset);
      if (gap_after[b] && b < BEATS - 1) begin
        tick();
        check("load.gap_wa_valid", longint'(bus.wa_valid), 0);
      end
    end
    check("load.s_ready_off", longint'(bus.s_ready), 0);
    check("load.busy_off", longint'(bus.busy), 0);
    tick();
    check("load.wa_valid_off", longint'(bus.wa_valid), 0);
    check("load.loaded", longint'(bus.loaded), 1);
  endtask

  task automatic eval_pass(input int n, input logic [CLAUSEN-1:0] fire, input int exp_sum);
    int c;
    bus.start       = 1'b1;
    bus.clauses     = 5'(n);
    bus.clause_fire = fire;
    tick();
    bus.start = 1'b0;
    check("eval.busy", longint'(bus.busy), 1);
    c = 1;
    while (!bus.done && c < 40) begin
      if (c <= n) check("eval.clause_no", longint'(bus.wa_clause_no), longint'(c - 1));
      tick();
      c++;
    end
    check("eval.done_cycle", longint'(c), longint'(n + 2));
    check("eval.class_sum", longint'(bus.class_sum), longint'(exp_sum));
    check("eval.clause_no_hold", longint'(bus.wa_clause_no), longint'(n - 1));
    $display("eval clauses=%0d fire=%b -> class_sum=%0d done_cycle=%0d", n, fire, bus.class_sum, c);
    tick();
    check("eval.done_pulse", longint'(bus.done), 0);
    check("eval.busy_off", longint'(bus.busy), 0);
    check("eval.sum_hold", longint'(bus.class_sum), longint'(exp_sum));
  endtask

  task automatic bad_start(input string tag, input int n, input int exp_clause_no);
    bus.start       = 1'b1;
    bus.clauses     = 5'(n);
    bus.clause_fire = '1;
    tick();
    bus.start = 1'b0;
    check({tag, ".err"}, longint'(bus.err), 1);
    check({tag, ".busy"}, longint'(bus.busy), 0);
    for (int i = 0; i < 4; i++) begin
      check({tag, ".no_done"}, longint'(bus.done), 0);
      check({tag, ".clause_no"}, longint'(bus.wa_clause_no), longint'(exp_clause_no));
      tick();
    end
    $display("start rejected (%s, clauses=%0d) err=%0d", tag, n, bus.err);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) wtab[i] = '0;
    rst_n           = 1'b0;
    bus.load_start  = 1'b0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.start       = 1'b0;
    bus.clauses     = '0;
    bus.clause_fire = '0;
    repeat (3) tick();
    check_all_zero("reset");
    #4 rst_n = 1'b1;
    tick();

    bad_start("unloaded", 4, 0);
    load_image(8'h00);
    bad_start("clauses0", 0, 0);
    load_image(8'b0000_1010);
    bad_start("clauses11", 11, 0);
    load_image(8'h00);
    check("err_cleared", longint'(bus.err), 0);

    for (int i = 0; i < 10; i++) wtab[i] = (i % 2 == 0) ? 9'h003 : 9'h1FB;
    eval_pass(10, 10'b11_1111_1111, -10);

    wtab[0] = 9'h0FF; wtab[1] = 9'h100; wtab[2] = 9'h0FF; wtab[3] = 9'h100;
    eval_pass(4, 10'b00_0000_0101, 510);
    wtab[0] = 9'h100; wtab[2] = 9'h100;
    eval_pass(4, 10'b00_0000_0101, -512);

    wtab[0] = 9'h1FF;
    eval_pass(1, 10'b00_0000_0001, -1);

    // Async reset in the middle of a pass at k=5.
    for (int i = 0; i < 10; i++) wtab[i] = 9'h001;
    bus.start       = 1'b1;
    bus.clauses     = 5'd10;
    bus.clause_fire = '1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("midreset.k5", longint'(bus.wa_clause_no), 5);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    #2 rst_n = 1'b1;
    $display("reset asserted mid-EVAL at k=5");
    tick();
    check("midreset.no_done", longint'(bus.done), 0);
    bad_start("after_reset", 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
